// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU request arbiter and its sub-blocks:
//   - default datapath widths and timeout
//   - ALU opcode constants (passed through undecoded by the arbiter)
//   - sequencer FSM state encoding
//   - one-hot helper for two-requester vectors
package alu_pkg;

    localparam int WIDTH_DEF   = 8;
    localparam int OPW_DEF     = 3;
    localparam int TIMEOUT_DEF = 16;

    localparam logic [OPW_DEF-1:0] OP_ADD = 3'd0;
    localparam logic [OPW_DEF-1:0] OP_SUB = 3'd1;
    localparam logic [OPW_DEF-1:0] OP_AND = 3'd2;
    localparam logic [OPW_DEF-1:0] OP_OR  = 3'd3;
    localparam logic [OPW_DEF-1:0] OP_XOR = 3'd4;
    localparam logic [OPW_DEF-1:0] OP_NOT = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Requester index to its bit in a 2-wide one-hot vector.
    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-way round-robin pick. Purely combinational; the caller owns the
// last-grant pointer and updates it when a transaction retires.
// Ports:
//   req   in  [1:0]  request vector
//   last  in  1      index of the requester served most recently
//   gnt   out [1:0]  one-hot winner (0 when no request)
//   idx   out 1      winner index (0 when no request)
//   any   out 1      at least one request present
module rr_arb2
    import alu_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       idx,
    output logic       any
);

    always_comb begin
        // NOTE: every output gets a value before the case so no path can
        // leave one unassigned and infer a latch.
        idx = 1'b0;
        gnt = 2'b00;
        any = |req;
        case (req)
            2'b01:   idx = 1'b0;
            2'b10:   idx = 1'b1;
            2'b11:   idx = ~last;   // contention: the one not served last
            default: idx = 1'b0;
        endcase
        if (any) begin
            gnt = onehot2(idx);
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter
// Round-robin arbiter and sequencer placing two requesters in front of one
// shared ALU. One operation is in flight at a time: a request is captured,
// issued with a start pulse, the arbiter waits for done, then returns the
// result to the owner with a valid/ready handshake.
//
// Build option:
//   ALU_TIMEOUT_EN  when defined, WAIT aborts after TIMEOUT cycles without
//                   alu_done and answers with rsp_data=0, rsp_err=1.
//                   When undefined, rsp_err is tied low and WAIT never ends
//                   without alu_done.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   req[2]                per-requester request, held with data until gnt
//   req_x/req_y/req_op    packed operands/opcode, requester i at slice i
//   gnt[2]                one-cycle grant pulse
//   alu_x/alu_y/alu_op    operands/opcode to the ALU, held ISSUE..WAIT
//   alu_start             one-cycle start pulse
//   alu_done/alu_result   ALU completion strobe and its result
//   rsp_valid[2]          response valid for the owning requester
//   rsp_ready[2]          response accept per requester
//   rsp_data, rsp_err     response payload and timeout-abort flag
module alu_req_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int OPW     = OPW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req,
    input  logic [2*WIDTH-1:0] req_x,
    input  logic [2*WIDTH-1:0] req_y,
    input  logic [2*OPW-1:0]   req_op,
    output logic [1:0]         gnt,
    output logic [WIDTH-1:0]   alu_x,
    output logic [WIDTH-1:0]   alu_y,
    output logic [OPW-1:0]     alu_op,
    output logic               alu_start,
    input  logic               alu_done,
    input  logic [WIDTH-1:0]   alu_result,
    output logic [1:0]         rsp_valid,
    input  logic [1:0]         rsp_ready,
    output logic [WIDTH-1:0]   rsp_data,
    output logic               rsp_err
);

    // A TIMEOUT below 1 has no meaningful abort window; this marker net
    // only exists in such a configuration so lint draws attention to it.
    if (TIMEOUT < 1) begin : g_timeout_range
        logic illegal_timeout;
        assign illegal_timeout = 1'b1;
    end

    state_t state;
    logic   last_gnt;   // requester served most recently
    logic   owner;      // requester owning the op in flight

    logic [1:0] pick_gnt;
    logic       pick_idx;
    logic       pick_any;

    rr_arb2 u_arb (
        .req  (req),
        .last (last_gnt),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

`ifdef ALU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;
`else
    assign rsp_err = 1'b0;
`endif

    // NOTE: all state here is updated with <= so every register samples
    // pre-edge values and ordering of statements cannot change behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;   // requester 0 wins the first contention
            owner     <= 1'b0;
            gnt       <= 2'b00;
            alu_x     <= '0;
            alu_y     <= '0;
            alu_op    <= '0;
            alu_start <= 1'b0;
            rsp_valid <= 2'b00;
            rsp_data  <= '0;
`ifdef ALU_TIMEOUT_EN
            rsp_err   <= 1'b0;
            wait_cnt  <= '0;
`endif
        end else begin
            // Pulses default low and are raised for a single cycle below.
            gnt       <= 2'b00;
            alu_start <= 1'b0;

            case (state)
                IDLE: begin
                    if (pick_any) begin
                        gnt    <= pick_gnt;
                        owner  <= pick_idx;
                        alu_x  <= pick_idx ? req_x[WIDTH +: WIDTH] : req_x[0 +: WIDTH];
                        alu_y  <= pick_idx ? req_y[WIDTH +: WIDTH] : req_y[0 +: WIDTH];
                        alu_op <= pick_idx ? req_op[OPW +: OPW]    : req_op[0 +: OPW];
                        state  <= ISSUE;
                    end
                end

                ISSUE: begin
                    alu_start <= 1'b1;
`ifdef ALU_TIMEOUT_EN
                    wait_cnt  <= '0;
`endif
                    state     <= WAIT;
                end

                WAIT: begin
                    if (alu_done) begin
                        rsp_data  <= alu_result;
`ifdef ALU_TIMEOUT_EN
                        rsp_err   <= 1'b0;
`endif
                        rsp_valid <= onehot2(owner);
                        state     <= RESP;
                    end
`ifdef ALU_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT)) begin
                        // Abort: answer with an error; a late done lands
                        // outside WAIT and is ignored.
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= onehot2(owner);
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end

                RESP: begin
                    // Only the owner's ready retires the response.
                    if (rsp_ready[owner]) begin
                        rsp_valid <= 2'b00;
                        last_gnt  <= owner;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter
// Directed bench for alu_req_arbiter: a behavioural ALU with programmable
// latency, a scoreboard of expected responses pushed at stimulus time and
// popped when rsp_valid appears, and immediate assertions at every check.
module tb_alu_req_arbiter;
    import alu_pkg::*;

    localparam int W   = 8;
    localparam int OPW = 3;
    localparam int TO  = 16;

    typedef struct packed {
        logic         owner;
        logic [W-1:0] data;
        logic         err;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       req = '0;
    logic [2*W-1:0]   req_x = '0;
    logic [2*W-1:0]   req_y = '0;
    logic [2*OPW-1:0] req_op = '0;
    logic [1:0]       gnt;
    logic [W-1:0]     alu_x;
    logic [W-1:0]     alu_y;
    logic [OPW-1:0]   alu_op;
    logic             alu_start;
    logic             alu_done;
    logic [W-1:0]     alu_result;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready = '0;
    logic [W-1:0]     rsp_data;
    logic             rsp_err;

    logic             model_done = 1'b0;
    logic             inj_done = 1'b0;
    logic [W-1:0]     model_res = '0;
    assign alu_done   = model_done | inj_done;
    assign alu_result = model_res;

    int   passed = 0;
    int   total  = 0;
    exp_t sb[$];

    int       alu_delay   = 3;
    bit       alu_respond = 1'b1;
    bit       pend        = 1'b0;
    int       cd          = 0;
    logic [W-1:0] res_q   = '0;

    alu_req_arbiter #(.WIDTH(W), .OPW(OPW), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_op     (req_op),
        .gnt        (gnt),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_op     (alu_op),
        .alu_start  (alu_start),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_ref(input logic [OPW-1:0] op,
                                             input logic [W-1:0] x,
                                             input logic [W-1:0] y);
        case (op)
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            OP_AND:  return x & y;
            OP_OR:   return x | y;
            OP_XOR:  return x ^ y;
            OP_NOT:  return ~x;
            default: return '0;
        endcase
    endfunction

    // Behavioural ALU: done is high alu_delay cycles after the start cycle.
    always @(posedge clk) begin
        model_done <= 1'b0;
        if (alu_start && alu_respond) begin
            pend  = 1'b1;
            cd    = alu_delay;
            res_q = alu_ref(alu_op, alu_x, alu_y);
        end else if (pend) begin
            cd = cd - 1;
            if (cd <= 1) begin
                model_done <= 1'b1;
                model_res  <= res_q;
                pend = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push_exp(input logic owner, input logic [W-1:0] data, input logic err);
        exp_t e;
        e.owner = owner;
        e.data  = data;
        e.err   = err;
        sb.push_back(e);
    endtask

    task automatic set_req(input int i, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [OPW-1:0] op);
        req_x[i*W +: W]     = x;
        req_y[i*W +: W]     = y;
        req_op[i*OPW +: OPW] = op;
    endtask

    task automatic check_outs_zero(input string tag);
        check({tag, "_ctl"},  32'({gnt, alu_start, rsp_valid, rsp_err}), 0);
        check({tag, "_data"}, 32'({alu_x, alu_y, alu_op, rsp_data}), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_gnt(input string tag, input int exp, input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while (gnt == 2'b00 && n < budget);
        check(tag, 32'(gnt), exp);
    endtask

    task automatic wait_rsp(input string tag, input int budget, output int lat);
        exp_t e;
        int   n = 0;
        while (rsp_valid == 2'b00 && n < budget) begin
            tick();
            n++;
        end
        lat = n;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb.size()), 1);
        end else begin
            e = sb.pop_front();
            check({tag, "_vld"},  32'(rsp_valid), 32'(onehot2(e.owner)));
            check({tag, "_data"}, 32'(rsp_data),  32'(e.data));
            check({tag, "_err"},  32'(rsp_err),   32'(e.err));
        end
    endtask

    task automatic ack(input string tag, input logic owner);
        rsp_ready = onehot2(owner);
        tick();
        check({tag, "_clr"}, 32'(rsp_valid), 0);
        rsp_ready = 2'b00;
    endtask

    // Counts cycles with any response or grant over a window; expects none.
    task automatic quiet(input string tag, input int cycles);
        int hits = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (rsp_valid != 2'b00 || gnt != 2'b00) hits++;
        end
        check(tag, 32'(hits), 0);
    endtask

    initial begin
        int lat;

        // Reset state
        tick();
        tick();
        check_outs_zero("rst");
        rst_n = 1'b1;
        tick();

        // Single requester, AND, done 3 cycles after start
        set_req(0, 8'h07, 8'h02, OP_AND);
        push_exp(1'b0, 8'h02, 1'b0);
        req = 2'b01;
        wait_gnt("t1_gnt", 1, 8);
        check("t1_alu_x", 32'(alu_x), 'h07);
        check("t1_alu_y", 32'(alu_y), 'h02);
        check("t1_alu_op", 32'(alu_op), 32'(OP_AND));
        check("t1_start_c0", 32'(alu_start), 0);
        req = 2'b00;
        tick();
        check("t1_start_c1", 32'(alu_start), 1);
        tick();
        check("t1_start_c2", 32'(alu_start), 0);
        wait_rsp("t1", 20, lat);
        check("t1_lat", 32'(lat + 2), 5);
        ack("t1", 1'b0);

        // Both requesting continuously from reset: grants alternate
        do_reset();
        set_req(0, 8'd5, 8'd3, OP_ADD);
        set_req(1, 8'd10, 8'd20, OP_ADD);
        for (int i = 0; i < 4; i++) push_exp(i[0], i[0] ? 8'h1E : 8'h08, 1'b0);
        rsp_ready = 2'b11;
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_gnt($sformatf("t2_gnt%0d", i), i[0] ? 2 : 1, 10);
            wait_rsp($sformatf("t2_rsp%0d", i), 20, lat);
        end
        req = 2'b00;
        tick();
        rsp_ready = 2'b00;
        check("t2_idle_vld", 32'(rsp_valid), 0);

        // Backpressure in RESP with requester 1 pending
        set_req(0, 8'h3C, 8'h0F, OP_XOR);
        push_exp(1'b0, 8'h33, 1'b0);
        req = 2'b01;
        wait_gnt("t3_gnt0", 1, 10);
        set_req(1, 8'h55, 8'hAA, OP_OR);
        push_exp(1'b1, 8'hFF, 1'b0);
        req = 2'b10;
        wait_rsp("t3_r0", 20, lat);
        rsp_ready = 2'b10;   // non-owner ready must be ignored
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t3_hold_vld%0d", i), 32'(rsp_valid), 1);
            check($sformatf("t3_hold_data%0d", i), 32'(rsp_data), 'h33);
            check($sformatf("t3_hold_gnt%0d", i), 32'(gnt), 0);
        end
        rsp_ready = 2'b00;
        ack("t3_a0", 1'b0);
        wait_gnt("t3_gnt1", 2, 10);
        req = 2'b00;
        wait_rsp("t3_r1", 20, lat);
        ack("t3_a1", 1'b1);

        // Reset while waiting on the ALU; the stale done must be ignored
        alu_delay = 6;
        set_req(0, 8'h01, 8'h02, OP_ADD);
        req = 2'b01;
        wait_gnt("t4_gnt", 1, 10);
        req = 2'b00;
        tick();
        tick();
        check("t4_held_x", 32'(alu_x), 'h01);
        rst_n = 1'b0;
        #1;
        check_outs_zero("t4_rst");
        tick();
        rst_n = 1'b1;
        quiet("t4_stale", 12);
        alu_delay = 3;
        set_req(0, 8'h11, 8'h22, OP_ADD);
        push_exp(1'b0, 8'h33, 1'b0);
        req = 2'b01;
        wait_gnt("t4_gnt2", 1, 10);
        req = 2'b00;
        wait_rsp("t4_r", 20, lat);
        check("t4_lat", 32'(lat), 5);
        ack("t4", 1'b0);

        // Spurious done while idle
        inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        quiet("t5_idle_done", 5);
        set_req(0, 8'hF0, 8'h00, OP_NOT);
        push_exp(1'b0, 8'h0F, 1'b0);
        req = 2'b01;
        wait_gnt("t5_gnt", 1, 1);
        req = 2'b00;
        wait_rsp("t5_r", 20, lat);
        ack("t5", 1'b0);

        // ALU never answers
        alu_respond = 1'b0;
        set_req(0, 8'h12, 8'h34, OP_SUB);
`ifdef ALU_TIMEOUT_EN
        push_exp(1'b0, 8'h00, 1'b1);
`endif
        req = 2'b01;
        wait_gnt("t6_gnt", 1, 10);
        req = 2'b00;
`ifdef ALU_TIMEOUT_EN
        wait_rsp("t6_to", 40, lat);
        check("t6_lat", 32'(lat), TO + 2);
        ack("t6", 1'b0);
        inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        quiet("t6_late_done", 5);
`else
        quiet("t6_no_rsp", 100);
        do_reset();
`endif
        alu_respond = 1'b1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of one shared 8-bit ALU unit. The ALU unit has x/y operands, an opcode, start and done.
- Captures one request, issues it to the ALU, waits for done, then returns the result to the owning requester with a valid/ready handshake.
- Sits between client logic (e.g. instruction sequencer, test driver) and the ALU datapath. Only one operation is in flight at a time.

Parameters:
- WIDTH, 8, operand/result width.
- OPW, 3, opcode width; opcodes pass through undecoded.
- TIMEOUT, 16, max WAIT cycles before abort (used only with ALU_TIMEOUT_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  2  request per requester i; held with data until gnt[i].
- req_x  in  2*WIDTH  operand x; requester i at [i*WIDTH +: WIDTH].
- req_y  in  2*WIDTH  operand y, same packing.
- req_op  in  2*OPW  opcode, same packing.
- gnt  out  2  one-cycle pulse; request i captured this cycle.
- alu_x, alu_y  out  WIDTH  operands to ALU; stable from ISSUE through WAIT.
- alu_op  out  OPW  opcode to ALU; stable with operands.
- alu_start  out  1  one-cycle start pulse.
- alu_done  in  1  ALU completion strobe.
- alu_result  in  WIDTH  ALU result; valid when alu_done=1.
- rsp_valid  out  2  response valid for requester i (at most one bit set).
- rsp_ready  in  2  response accept per requester.
- rsp_data  out  WIDTH  result for the owning requester.
- rsp_err  out  1  timeout abort flag, qualified by rsp_valid.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; last-grant pointer=1, so requester 0 wins first.
  - All outputs 0: gnt, alu_x/y/op, alu_start, rsp_valid, rsp_data, rsp_err.
  - Reset mid-operation abandons the op with no response. A stale alu_done arriving after reset is ignored.
- FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req bit set, pick the winner and pulse gnt[winner].
  - Latch winner's x/y/op into alu_x/y/op and record owner; go ISSUE.
  - Both requesting: winner is the requester NOT equal to the last-grant pointer. Single requester always wins.
- ISSUE: alu_start=1 for exactly one cycle; go WAIT.
- WAIT:
  - On alu_done=1, latch alu_result into rsp_data, rsp_err=0; go RESP.
  - alu_done in IDLE/ISSUE/RESP is ignored.
- RESP:
  - rsp_valid[owner]=1; rsp_data held stable.
  - On rsp_ready[owner]=1: clear rsp_valid, update last-grant pointer=owner, go IDLE.
  - rsp_ready of the non-owner is ignored.
- Latency:
  - gnt at cycle 0, alu_start at cycle 1.
  - If alu_done arrives at cycle k, rsp_valid rises at k+1.
  - With rsp_ready held high, IDLE is re-entered at k+2. Next gnt is no earlier than k+2.
- Requests asserted while busy are not granted. The requester holds them; no queuing.
- rsp_ready high before rsp_valid is legal; the handshake completes in the first RESP cycle.
- No arithmetic in this block; widths pass through unmodified.

Optional Feature:
- ALU_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT with no alu_done: go RESP with rsp_data=0, rsp_err=1.
  - A late alu_done is then ignored.
- Not defined: rsp_err tied 0, no counter; WAIT waits indefinitely.

Decomposition:
- Shared package alu_pkg:
  - Opcode constants OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_XOR=4, OP_NOT=5.
  - FSM state encoding IDLE=0, ISSUE=1, WAIT=2, RESP=3.
  - Default WIDTH/OPW.
- One sub-module: rr_arb2, a 2-way round-robin pick from req and the last-grant pointer. Purely combinational, reused by later multi-unit schedulers.

Test Plan:
- Reset, then req=01, x0=8'h07, y0=8'h02, op0=OP_AND. ALU model returns done 3 cycles after start -> gnt=01 cycle 0, alu_start cycle 1, rsp_valid=01, rsp_data=8'h02, rsp_err=0.
- Both req every cycle from reset, ALU adds, x0=5/y0=3, x1=10/y1=20 -> grants alternate 01,10,01,10. Responses 8'h08 and 8'h1E go to the matching rsp_valid bit.
- rsp_ready held low 5 cycles in RESP -> rsp_valid/rsp_data stable; no new gnt; req[1] pending is granted only after the ready.
- rst_n pulsed low during WAIT -> all outputs 0 immediately. A later alu_done produces no rsp_valid; next req=01 is granted normally.
- ALU_TIMEOUT_EN, TIMEOUT=16, ALU never responds -> rsp_valid at WAIT entry+17, rsp_err=1, rsp_data=0. Without the macro, no response after 100 cycles.
- alu_done pulsed while IDLE with no request -> no state change, rsp_valid stays 0.
